// File: rtl/noise_sample_streamer_if.sv
// Sample-memory read port plus the noise stream toward the noise-mean accumulator.
// master = streamer side; slave = memories and accumulator side.
interface noise_sample_streamer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 13
);
  logic                         mem_rd_en;
  logic [ADDR_WIDTH-1:0]        mem_addr;
  logic signed [DATA_WIDTH-1:0] raw_sample;
  logic signed [DATA_WIDTH-1:0] filt_sample;
  logic                         valid_noise;
  logic signed [DATA_WIDTH-1:0] noise_signal;

  modport master (
    output mem_rd_en,
    output mem_addr,
    input  raw_sample,
    input  filt_sample,
    output valid_noise,
    output noise_signal
  );

  modport slave (
    input  mem_rd_en,
    input  mem_addr,
    output raw_sample,
    output filt_sample,
    input  valid_noise,
    input  noise_signal
  );
endinterface

// File: rtl/noise_sample_streamer.sv
// Streams MEMORY_DEPTH saturated (raw - filt) samples then one zero flush beat; 2 cycles start-to-first-beat, D+3 to done.
// No backpressure: the consumer must accept a beat on every cycle valid_noise is high.
module noise_sample_streamer #(
  parameter int DATA_WIDTH   = 16,
  parameter int MEMORY_DEPTH = 5968,
  parameter int ADDR_WIDTH   = 13
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  noise_sample_streamer_if.master bus,
  output logic                    busy,
  output logic                    done_stream
);
  typedef enum logic [2:0] {IDLE, READ, DRAIN, FLUSH, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0]        LAST_ADDR = ADDR_WIDTH'(MEMORY_DEPTH - 1);
  localparam logic signed [DATA_WIDTH-1:0] SAT_MAX   = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] SAT_MIN   = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t                       state;
  logic                         rd_dat_vld;
  logic                         flush_sent;
  logic signed [DATA_WIDTH:0]   diff;
  logic signed [DATA_WIDTH-1:0] diff_sat;

  // One guard bit is enough: disagreement between the top two bits means overflow.
  always_comb begin
    diff     = {bus.raw_sample[DATA_WIDTH-1], bus.raw_sample}
             - {bus.filt_sample[DATA_WIDTH-1], bus.filt_sample};
    diff_sat = diff[DATA_WIDTH-1:0];
    if (diff[DATA_WIDTH] != diff[DATA_WIDTH-1]) begin
      diff_sat = diff[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      rd_dat_vld       <= 1'b0;
      flush_sent       <= 1'b0;
      bus.mem_rd_en    <= 1'b0;
      bus.mem_addr     <= '0;
      bus.valid_noise  <= 1'b0;
      bus.noise_signal <= '0;
      busy             <= 1'b0;
      done_stream      <= 1'b0;
    end else begin
      rd_dat_vld       <= bus.mem_rd_en;
      bus.valid_noise  <= rd_dat_vld;
      bus.noise_signal <= rd_dat_vld ? diff_sat : '0;

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state         <= READ;
            bus.mem_rd_en <= 1'b1;
            bus.mem_addr  <= '0;
            busy          <= 1'b1;
            done_stream   <= 1'b0;
          end
        end
        READ: begin
          if (bus.mem_addr == LAST_ADDR) begin
            bus.mem_rd_en <= 1'b0;
            state         <= DRAIN;
          end else begin
            bus.mem_addr <= bus.mem_addr + ADDR_WIDTH'(1);
          end
        end
        DRAIN: state <= FLUSH;
        // First FLUSH cycle puts out the zero beat, second one retires the run.
        FLUSH: begin
          if (!flush_sent) begin
            bus.valid_noise  <= 1'b1;
            bus.noise_signal <= '0;
            flush_sent       <= 1'b1;
          end else begin
            flush_sent  <= 1'b0;
            state       <= DONE;
            busy        <= 1'b0;
            done_stream <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_noise_sample_streamer.sv
// Directed bench: a depth-4 streamer for protocol/saturation/reset cases and a full-depth one feeding an accumulator model.
module tb_noise_sample_streamer;
  localparam int DW     = 16;
  localparam int AW     = 13;
  localparam int DEPTH4 = 4;
  localparam int DEPTHF = 5968;

  logic clk;
  logic reset_n;
  logic start4;
  logic startf;
  logic busy4, done4, busyf, donef;

  int checks = 0;
  int errors = 0;

  logic signed [DW-1:0] raw4  [DEPTH4];
  logic signed [DW-1:0] filt4 [DEPTH4];

  noise_sample_streamer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus4 ();
  noise_sample_streamer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) busf ();

  noise_sample_streamer #(.DATA_WIDTH(DW), .MEMORY_DEPTH(DEPTH4), .ADDR_WIDTH(AW)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .bus(bus4.master),
    .busy(busy4), .done_stream(done4)
  );

  noise_sample_streamer #(.DATA_WIDTH(DW), .MEMORY_DEPTH(DEPTHF), .ADDR_WIDTH(AW)) dutf (
    .clk(clk), .reset_n(reset_n), .start(startf), .bus(busf.master),
    .busy(busyf), .done_stream(donef)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read sample memories
  always @(posedge clk) begin
    if (bus4.mem_rd_en) begin
      bus4.raw_sample  <= raw4[bus4.mem_addr[1:0]];
      bus4.filt_sample <= filt4[bus4.mem_addr[1:0]];
    end
    if (busf.mem_rd_en) begin
      busf.raw_sample  <= DW'(busf.mem_addr);
      busf.filt_sample <= '0;
    end
  end

  task automatic test_reset();
    reset_n = 1'b0;
    start4  = 1'b1;
    startf  = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus4.mem_rd_en, bus4.mem_addr, bus4.valid_noise, bus4.noise_signal, busy4, done4} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_dut4: got rd=%b addr=%0d vld=%b noise=%0d busy=%b done=%b, want all 0",
               bus4.mem_rd_en, bus4.mem_addr, bus4.valid_noise, bus4.noise_signal, busy4, done4);
    end
    checks++;
    if ({busf.mem_rd_en, busf.mem_addr, busf.valid_noise, busf.noise_signal, busyf, donef} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_dutf: got rd=%b addr=%0d vld=%b busy=%b done=%b, want all 0",
               busf.mem_rd_en, busf.mem_addr, busf.valid_noise, busyf, donef);
    end
    start4  = 1'b0;
    startf  = 1'b0;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus4.mem_rd_en, bus4.valid_noise, busy4, done4} !== 4'b0) begin
      errors++;
      $display("FAIL reset_no_activity: got rd=%b vld=%b busy=%b done=%b, want 0000",
               bus4.mem_rd_en, bus4.valid_noise, busy4, done4);
    end
  endtask

  task automatic test_basic();
    logic signed [DW-1:0] exp_dat [DEPTH4];
    logic [AW-1:0]        exp_addr;
    logic signed [DW-1:0] exp_noise;
    raw4[0] = 16'sd100; raw4[1] = 16'sd200; raw4[2] = -16'sd50; raw4[3] = 16'sd0;
    filt4[0] = 16'sd90; filt4[1] = 16'sd250; filt4[2] = -16'sd50; filt4[3] = 16'sd10;
    exp_dat[0] = 16'sd10; exp_dat[1] = -16'sd50; exp_dat[2] = 16'sd0; exp_dat[3] = -16'sd10;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    for (int c = 0; c < 9; c++) begin
      exp_addr  = (c < DEPTH4) ? AW'(c) : AW'(DEPTH4 - 1);
      exp_noise = '0;
      if (c >= 2 && c <= DEPTH4 + 1) exp_noise = exp_dat[c-2];
      checks++;
      if (bus4.mem_rd_en !== (c < DEPTH4) || bus4.mem_addr !== exp_addr) begin
        errors++;
        $display("FAIL basic_read c=%0d: got rd=%b addr=%0d, want rd=%b addr=%0d",
                 c, bus4.mem_rd_en, bus4.mem_addr, (c < DEPTH4), exp_addr);
      end
      checks++;
      if (bus4.valid_noise !== (c >= 2 && c <= DEPTH4 + 2) || bus4.noise_signal !== exp_noise) begin
        errors++;
        $display("FAIL basic_stream c=%0d: got vld=%b noise=%0d, want vld=%b noise=%0d",
                 c, bus4.valid_noise, bus4.noise_signal, (c >= 2 && c <= DEPTH4 + 2), exp_noise);
      end
      checks++;
      if (busy4 !== (c <= DEPTH4 + 2) || done4 !== (c >= DEPTH4 + 3)) begin
        errors++;
        $display("FAIL basic_status c=%0d: got busy=%b done=%b, want busy=%b done=%b",
                 c, busy4, done4, (c <= DEPTH4 + 2), (c >= DEPTH4 + 3));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_saturation();
    logic signed [DW-1:0] exp_dat [DEPTH4];
    raw4[0] = 16'sd32767;  filt4[0] = -16'sd1;     exp_dat[0] = 16'sd32767;
    raw4[1] = -16'sd32768; filt4[1] = 16'sd1;      exp_dat[1] = -16'sd32768;
    raw4[2] = -16'sd32768; filt4[2] = -16'sd32768; exp_dat[2] = 16'sd0;
    raw4[3] = 16'sd32767;  filt4[3] = -16'sd32768; exp_dat[3] = 16'sd32767;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    for (int c = 0; c < 9; c++) begin
      if (c >= 2 && c <= DEPTH4 + 1) begin
        checks++;
        if (bus4.valid_noise !== 1'b1 || bus4.noise_signal !== exp_dat[c-2]) begin
          errors++;
          $display("FAIL saturation beat=%0d: got vld=%b noise=%0d, want vld=1 noise=%0d",
                   c - 2, bus4.valid_noise, bus4.noise_signal, exp_dat[c-2]);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_start_ignored();
    int beats = 0;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (bus4.valid_noise === 1'b1) beats++;
      if (c == 3) begin
        checks++;
        if (bus4.mem_addr !== AW'(3)) begin
          errors++;
          $display("FAIL start_ignored_addr: got addr=%0d, want 3", bus4.mem_addr);
        end
      end
      start4 = (c == 1 || c == 2 || c == 5);
      @(negedge clk);
    end
    start4 = 1'b0;
    checks++;
    if (beats != DEPTH4 + 1) begin
      errors++;
      $display("FAIL start_ignored_beats: got %0d beats, want %0d", beats, DEPTH4 + 1);
    end
    checks++;
    if (done4 !== 1'b1 || busy4 !== 1'b0) begin
      errors++;
      $display("FAIL start_ignored_done: got done=%b busy=%b, want done=1 busy=0", done4, busy4);
    end
  endtask

  task automatic test_back_to_back();
    start4 = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 9; c++) begin
      if (c == 0 || c == 8) begin
        checks++;
        if (done4 !== 1'b0 || busy4 !== 1'b1 || bus4.mem_rd_en !== 1'b1 || bus4.mem_addr !== '0) begin
          errors++;
          $display("FAIL b2b_restart c=%0d: got done=%b busy=%b rd=%b addr=%0d, want 0 1 1 0",
                   c, done4, busy4, bus4.mem_rd_en, bus4.mem_addr);
        end
      end
      if (c == 7) begin
        checks++;
        if (done4 !== 1'b1 || busy4 !== 1'b0) begin
          errors++;
          $display("FAIL b2b_done c=%0d: got done=%b busy=%b, want done=1 busy=0", c, done4, busy4);
        end
      end
      if (c == 8) start4 = 1'b0;
      @(negedge clk);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (done4 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_done: got done=%b, want 1", done4);
    end
  endtask

  task automatic test_reset_mid_run();
    int beats = 0;
    int activity = 0;
    logic signed [DW-1:0] exp_dat [DEPTH4];
    raw4[0] = 16'sd100; raw4[1] = 16'sd200; raw4[2] = -16'sd50; raw4[3] = 16'sd0;
    filt4[0] = 16'sd90; filt4[1] = 16'sd250; filt4[2] = -16'sd50; filt4[3] = 16'sd10;
    exp_dat[0] = 16'sd10; exp_dat[1] = -16'sd50; exp_dat[2] = 16'sd0; exp_dat[3] = -16'sd10;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus4.valid_noise !== 1'b1 || bus4.noise_signal !== -16'sd50) begin
      errors++;
      $display("FAIL midrst_second_beat: got vld=%b noise=%0d, want vld=1 noise=-50",
               bus4.valid_noise, bus4.noise_signal);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus4.mem_rd_en, bus4.mem_addr, bus4.valid_noise, bus4.noise_signal, busy4, done4} !== '0) begin
      errors++;
      $display("FAIL midrst_async_clear: got rd=%b addr=%0d vld=%b noise=%0d busy=%b done=%b, want all 0",
               bus4.mem_rd_en, bus4.mem_addr, bus4.valid_noise, bus4.noise_signal, busy4, done4);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (bus4.valid_noise === 1'b1 || bus4.mem_rd_en === 1'b1) activity++;
      @(negedge clk);
    end
    checks++;
    if (activity != 0) begin
      errors++;
      $display("FAIL midrst_quiet: got %0d active cycles, want 0", activity);
    end
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (bus4.valid_noise === 1'b1) begin
        if (beats < DEPTH4) begin
          checks++;
          if (bus4.noise_signal !== exp_dat[beats]) begin
            errors++;
            $display("FAIL midrst_rerun_beat=%0d: got noise=%0d, want %0d",
                     beats, bus4.noise_signal, exp_dat[beats]);
          end
        end
        beats++;
      end
      @(negedge clk);
    end
    checks++;
    if (beats != DEPTH4 + 1 || done4 !== 1'b1) begin
      errors++;
      $display("FAIL midrst_rerun_end: got beats=%0d done=%b, want beats=%0d done=1",
               beats, done4, DEPTH4 + 1);
    end
  endtask

  task automatic test_full_depth();
    longint sum = 0;
    longint exp_sum;
    int     mean = -1;
    int     beats = 0;
    int     first_c = -1;
    int     last_c = -1;
    int     bad_dat = 0;
    logic   finished = 1'b0;
    exp_sum = longint'(DEPTHF) * longint'(DEPTHF - 1) / 2;
    startf = 1'b1;
    @(negedge clk);
    startf = 1'b0;
    for (int c = 0; c < DEPTHF + 40 && !finished; c++) begin
      if (busf.valid_noise === 1'b1) begin
        if (first_c < 0) first_c = c;
        last_c = c;
        if (beats < DEPTHF) begin
          if (busf.noise_signal !== DW'(beats)) bad_dat++;
          sum += longint'(busf.noise_signal);
        end else begin
          if (busf.noise_signal !== '0) bad_dat++;
          mean = int'(sum / DEPTHF);
        end
        beats++;
      end
      if (donef === 1'b1) finished = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL full_timeout: done_stream not seen within %0d cycles", DEPTHF + 40);
    end
    checks++;
    if (beats != DEPTHF + 1 || first_c != 2 || last_c != DEPTHF + 2) begin
      errors++;
      $display("FAIL full_beats: got beats=%0d first=%0d last=%0d, want %0d 2 %0d",
               beats, first_c, last_c, DEPTHF + 1, DEPTHF + 2);
    end
    checks++;
    if (bad_dat != 0) begin
      errors++;
      $display("FAIL full_data: got %0d wrong beat values, want 0", bad_dat);
    end
    checks++;
    if (sum != exp_sum || sum != 64'd17805528) begin
      errors++;
      $display("FAIL full_sum: got %0d, want %0d", sum, exp_sum);
    end
    checks++;
    if (mean != 2983) begin
      errors++;
      $display("FAIL full_mean: got %0d, want 2983", mean);
    end
    checks++;
    if (donef !== 1'b1 || busyf !== 1'b0) begin
      errors++;
      $display("FAIL full_done: got done=%b busy=%b, want done=1 busy=0", donef, busyf);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start4  = 1'b0;
    startf  = 1'b0;
    for (int i = 0; i < DEPTH4; i++) begin
      raw4[i]  = '0;
      filt4[i] = '0;
    end
    @(negedge clk);
    test_reset();
    test_basic();
    test_saturation();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    test_full_depth();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
